uart_tx_fifo: RTL and testbench

Parametrised UART transmitter. Successor to the fixed 8N1 transmitter: configurable data width, parity, stop bits and bit period, plus a valid/ready input port backed by a small FIFO so producers can queue words. Frames are sent back to back with no idle gap. Sits between the data producer (e.g. the Viterbi decoder output path) and the serial TX pin.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO.
// Data width, parity, stop bits and bit period are set by parameters.
// Queued words go out back to back, with no idle gap between frames.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 TX,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int DEPTH  = 1 << FIFO_AW;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS);
  localparam logic              PAR_INV   = (PARITY == 1);

  // Reject illegal configurations during elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
      PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_AW < 1) begin : g_bad_params
    $fatal(1, "uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]     wr_ptr;
  logic [FIFO_AW:0]     rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;
  logic [DATA_BITS-1:0] head;

  // The extra pointer MSB separates full from empty when the low bits match.
  assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign tx_ready   = !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign push       = tx_valid && !full;
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  // The FSM takes a word when idle, or on the very last cycle of a frame
  // so that the next start bit follows with no gap.
  assign pop       = !empty && ((state == IDLE) || frame_end);

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= tx_data;
    end
  end

  // FIFO pointers: advance on accepted pushes and on FSM pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Frame sequencer: bit timing, shifting and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      TX       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == STOP) && (baud_cnt == BAUD_PRE) && (bit_cnt == STOP_LAST);
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
      end
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shreg   <= head;
            par_bit <= (^head) ^ PAR_INV;
            state   <= START;
            TX      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            TX      <= shreg[0];
            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            bit_cnt <= BIT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              if (PARITY != 0) begin
                state <= PAR;
                TX    <= par_bit;
              end else begin
                state   <= STOP;
                TX      <= 1'b1;
                bit_cnt <= BIT_W'(1);
              end
            end else begin
              TX      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state   <= STOP;
            TX      <= 1'b1;
            bit_cnt <= BIT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ PAR_INV;
                state   <= START;
                TX      <= 1'b0;
              end else begin
                state   <= IDLE;
                TX      <= 1'b1;
                busy    <= 1'b0;
                bit_cnt <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo.
// Instance a: 8 data bits, even parity, 1 stop bit, 4 clocks per bit.
// Instance b: 7 data bits, odd parity, 2 stop bits, 3 clocks per bit.
module tb_uart_tx_fifo;

  localparam int FA = 44;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data_a;
  logic       tx_valid_a;
  logic       tx_ready_a;
  logic [2:0] fifo_count_a;
  logic       tx_a;
  logic       busy_a;
  logic       done_a;
  logic [6:0] tx_data_b;
  logic       tx_valid_b;
  logic       tx_ready_b;
  logic [2:0] fifo_count_b;
  logic       tx_b;
  logic       busy_b;
  logic       done_b;

  int n_vec;
  int n_err;
  bit cap_en;
  logic q_tx[$];
  logic q_done[$];
  logic q_busy[$];
  logic [7:0] exp_words[$];
  logic t1_seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  logic t2_seq[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};

  uart_tx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)
  ) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .fifo_count(fifo_count_a), .TX(tx_a),
    .busy(busy_a), .done(done_a)
  );

  uart_tx_fifo #(
    .DATA_BITS(7), .CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(2), .FIFO_AW(2)
  ) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .fifo_count(fifo_count_b), .TX(tx_b),
    .busy(busy_b), .done(done_b)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line level for instance a: bit slot idx of a frame carrying w.
  function automatic logic exp_bit_a(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (idx == 9) return ^w;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    tx_valid_a = v;
    tx_data_a  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cap_en) begin
      q_tx.push_back(tx_a);
      q_done.push_back(done_a);
      q_busy.push_back(busy_a);
    end
  endtask

  task automatic runCapture(input int total);
    for (int n = 0; n < total + 10 && q_tx.size() < total; n++) tick();
  endtask

  task automatic checkCapture(input string name);
    int total;
    int slot;
    total = exp_words.size() * FA + 1;
    checkOutput({name, "_len"}, q_tx.size(), total);
    for (int i = 0; i < total && i < q_tx.size(); i++) begin
      if (i < total - 1) begin
        slot = i % FA;
        checkOutput($sformatf("%s_tx[%0d]", name, i), q_tx[i],
                    exp_bit_a(exp_words[i / FA], slot / 4));
        checkOutput($sformatf("%s_done[%0d]", name, i), q_done[i], (slot == FA - 1));
        checkOutput($sformatf("%s_busy[%0d]", name, i), q_busy[i], 1);
      end else begin
        checkOutput({name, "_idle_tx"}, q_tx[i], 1);
        checkOutput({name, "_idle_busy"}, q_busy[i], 0);
        checkOutput({name, "_idle_done"}, q_done[i], 0);
      end
    end
    cap_en = 1'b0;
    q_tx.delete();
    q_done.delete();
    q_busy.delete();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cap_en     = 1'b0;
    rst        = 1'b1;
    tx_valid_b = 1'b0;
    tx_data_b  = '0;
    applyStimulus(0, 8'h00);

    // Reset state
    tick();
    checkOutput("rst_tx", tx_a, 1);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_ready", tx_ready_a, 1);
    checkOutput("rst_count", fifo_count_a, 0);
    checkOutput("rst_tx_b", tx_b, 1);
    rst = 1'b0;
    tick();
    checkOutput("idle_tx", tx_a, 1);

    // Test 1: 0xA5, even parity, one stop bit
    $display("[TB] single frame 0xA5");
    applyStimulus(1, 8'hA5);
    tick();
    applyStimulus(0, 8'h00);
    checkOutput("t1_count_after_push", fifo_count_a, 1);
    checkOutput("t1_tx_before_pop", tx_a, 1);
    checkOutput("t1_busy_before_pop", busy_a, 0);
    tick();
    checkOutput("t1_count_after_pop", fifo_count_a, 0);
    for (int i = 0; i < FA; i++) begin
      checkOutput($sformatf("t1_tx[%0d]", i), tx_a, t1_seq[i / 4]);
      checkOutput($sformatf("t1_done[%0d]", i), done_a, (i == FA - 1));
      checkOutput($sformatf("t1_busy[%0d]", i), busy_a, 1);
      tick();
    end
    checkOutput("t1_end_tx", tx_a, 1);
    checkOutput("t1_end_busy", busy_a, 0);
    checkOutput("t1_end_done", done_a, 0);

    // Test 2: 0x07 on 7 data bits, odd parity, two stop bits
    $display("[TB] single frame 0x07, 7O2");
    tx_valid_b = 1'b1;
    tx_data_b  = 7'h07;
    tick();
    tx_valid_b = 1'b0;
    checkOutput("t2_count_after_push", fifo_count_b, 1);
    tick();
    for (int i = 0; i < 33; i++) begin
      checkOutput($sformatf("t2_tx[%0d]", i), tx_b, t2_seq[i / 3]);
      checkOutput($sformatf("t2_done[%0d]", i), done_b, (i == 32));
      checkOutput($sformatf("t2_busy[%0d]", i), busy_b, 1);
      tick();
    end
    checkOutput("t2_end_tx", tx_b, 1);
    checkOutput("t2_end_busy", busy_b, 0);

    // Tests 3 and 4: fill the FIFO while busy, then push into a full FIFO
    $display("[TB] burst until full, then drop 0x3C");
    exp_words = '{8'h01, 8'h80, 8'h55, 8'hF0, 8'h0F};
    applyStimulus(1, 8'h01);
    tick();
    cap_en = 1'b1;
    applyStimulus(1, 8'h80);
    tick();
    checkOutput("t3_count1", fifo_count_a, 1);
    applyStimulus(1, 8'h55);
    tick();
    checkOutput("t3_count2", fifo_count_a, 2);
    applyStimulus(1, 8'hF0);
    tick();
    checkOutput("t3_count3", fifo_count_a, 3);
    checkOutput("t3_ready3", tx_ready_a, 1);
    applyStimulus(1, 8'h0F);
    tick();
    checkOutput("t3_count4", fifo_count_a, 4);
    checkOutput("t3_ready_full", tx_ready_a, 0);
    applyStimulus(1, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t4_count[%0d]", i), fifo_count_a, 4);
      checkOutput($sformatf("t4_ready[%0d]", i), tx_ready_a, 0);
    end
    applyStimulus(0, 8'h00);
    runCapture(5 * FA + 1);
    checkCapture("t3");
    checkOutput("t3_final_count", fifo_count_a, 0);

    // Test 6: push coinciding with a pop at the frame boundary
    $display("[TB] push and pop on the same edge");
    exp_words = '{8'h3A, 8'hC3, 8'h69, 8'h96};
    applyStimulus(1, 8'h3A);
    tick();
    cap_en = 1'b1;
    applyStimulus(1, 8'hC3);
    tick();
    applyStimulus(1, 8'h69);
    tick();
    applyStimulus(0, 8'h00);
    checkOutput("t6_count_before", fifo_count_a, 2);
    runCapture(FA);
    checkOutput("t6_done_at_boundary", done_a, 1);
    checkOutput("t6_count_at_boundary", fifo_count_a, 2);
    applyStimulus(1, 8'h96);
    tick();
    applyStimulus(0, 8'h00);
    checkOutput("t6_count_after", fifo_count_a, 2);
    checkOutput("t6_start_tx", tx_a, 0);
    checkOutput("t6_start_busy", busy_a, 1);
    runCapture(4 * FA + 1);
    checkCapture("t6");

    // Test 5: reset in the middle of frame 2 with two words still queued
    $display("[TB] reset mid-frame");
    applyStimulus(1, 8'h11);
    tick();
    applyStimulus(1, 8'h22);
    tick();
    applyStimulus(1, 8'h33);
    tick();
    applyStimulus(1, 8'h44);
    tick();
    applyStimulus(0, 8'h00);
    checkOutput("t5_count_queued", fifo_count_a, 3);
    repeat (52) tick();
    checkOutput("t5_count_mid", fifo_count_a, 2);
    checkOutput("t5_busy_mid", busy_a, 1);
    checkOutput("t5_tx_mid", tx_a, exp_bit_a(8'h22, 2));
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_tx", tx_a, 1);
    checkOutput("t5_rst_busy", busy_a, 0);
    checkOutput("t5_rst_done", done_a, 0);
    checkOutput("t5_rst_count", fifo_count_a, 0);
    checkOutput("t5_rst_ready", tx_ready_a, 1);
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("t5_post_tx", tx_a, 1);
    checkOutput("t5_post_busy", busy_a, 0);
    checkOutput("t5_post_count", fifo_count_a, 0);
    exp_words = '{8'h81};
    applyStimulus(1, 8'h81);
    tick();
    applyStimulus(0, 8'h00);
    cap_en = 1'b1;
    runCapture(FA + 1);
    checkCapture("t5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
